// File: rtl/vm_pkg.sv
// Shared vending-machine types: coin codes with their credit values, the
// default credit ceiling, and the credit unit's state encoding.
package vm_pkg;

  typedef enum logic [1:0] {
    COIN_5  = 2'd0,
    COIN_10 = 2'd1,
    COIN_20 = 2'd2,
    COIN_50 = 2'd3
  } coin_code_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_REFUND = 2'd2
  } credit_state_t;

  localparam int unsigned MAX_CREDIT_DEF = 75;

  // Credit value of each coin, in units of 100
  function automatic int unsigned coin_value(input coin_code_t code);
    case (code)
      COIN_5:  coin_value = 5;
      COIN_10: coin_value = 10;
      COIN_20: coin_value = 20;
      default: coin_value = 50;
    endcase
  endfunction

endpackage

// File: rtl/inactivity_timer.sv
// Counts tick pulses while enabled; asserts expired once TIMEOUT_S ticks have
// passed without a clear. Used only when COIN_TIMEOUT_EN is defined.
module inactivity_timer #(
  parameter int unsigned TIMEOUT_S = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_S + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_S);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!enable || clear)
      count_d = '0;
    else if (tick && (count_q != CNT_MAX))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expired = (count_q == CNT_MAX);

endmodule

// File: rtl/coin_credit_unit.sv
// Customer credit accumulator: coin crediting, purchase charge ack/nack and
// refund handshake. Optional inactivity refund under COIN_TIMEOUT_EN.
module coin_credit_unit
  import vm_pkg::*;
#(
  parameter int unsigned CREDIT_W   = 7,
  parameter int unsigned MAX_CREDIT = MAX_CREDIT_DEF,
  parameter int unsigned TIMEOUT_S  = 60
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick_1s,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  input  logic                charge_valid,
  input  logic [CREDIT_W-1:0] charge_amount,
  input  logic                refund_req,
  input  logic                session_end,
  input  logic                refund_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                charge_ack,
  output logic                charge_nack,
  output logic                coin_reject,
  output logic                refund_valid,
  output logic [CREDIT_W-1:0] refund_amount,
  output logic                idle
);

  localparam int unsigned XW = CREDIT_W + 1;
  localparam logic [XW-1:0] MAX_X = XW'(MAX_CREDIT);

  credit_state_t       state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] refund_amount_q, refund_amount_d;
  logic                refund_valid_q, refund_valid_d;
  logic                charge_ack_q, charge_ack_d;
  logic                charge_nack_q, charge_nack_d;
  logic                coin_reject_q, coin_reject_d;
  logic                idle_q, idle_d;

  logic                timeout;
  logic [XW-1:0]       coin_v, after_charge, after_coin;
  logic                charge_ok, coin_ok, refund_go;

`ifdef COIN_TIMEOUT_EN
  inactivity_timer #(.TIMEOUT_S(TIMEOUT_S)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick_1s),
    .clear   (coin_valid | charge_valid | (state_q != ST_CREDIT)),
    .enable  (state_q == ST_CREDIT),
    .expired (timeout)
  );
`else
  logic unused_tick;
  assign unused_tick = tick_1s;
  assign timeout     = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    refund_amount_d = refund_amount_q;
    refund_valid_d  = refund_valid_q;
    charge_ack_d    = 1'b0;
    charge_nack_d   = 1'b0;
    coin_reject_d   = 1'b0;

    coin_v       = XW'(coin_value(coin_code_t'(coin_code)));
    charge_ok    = (state_q != ST_REFUND) && (charge_amount <= credit_q);
    // Charge is decided first; the coin is tested against the post-charge credit
    after_charge = {1'b0, credit_q}
                 - ((charge_valid && charge_ok) ? {1'b0, charge_amount} : '0);
    after_coin   = after_charge + coin_v;
    coin_ok      = (state_q != ST_REFUND) && (after_coin <= MAX_X);
    refund_go    = refund_req || session_end || timeout;

    if (state_q == ST_REFUND) begin
      charge_nack_d = charge_valid;
      coin_reject_d = coin_valid;
      if (refund_ack && refund_valid_q) begin
        credit_d        = '0;
        refund_valid_d  = 1'b0;
        refund_amount_d = '0;
        state_d         = ST_IDLE;
      end
    end else begin
      if (charge_valid) begin
        charge_ack_d  = charge_ok;
        charge_nack_d = !charge_ok;
      end
      if (coin_valid && coin_ok)
        credit_d = after_coin[CREDIT_W-1:0];
      else
        credit_d = after_charge[CREDIT_W-1:0];
      coin_reject_d = coin_valid && !coin_ok;

      if (credit_d == '0)
        state_d = ST_IDLE;
      else if (state_q == ST_CREDIT && refund_go) begin
        state_d         = ST_REFUND;
        refund_valid_d  = 1'b1;
        refund_amount_d = credit_d;
      end else
        state_d = ST_CREDIT;
    end

    idle_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      credit_q        <= '0;
      refund_amount_q <= '0;
      refund_valid_q  <= 1'b0;
      charge_ack_q    <= 1'b0;
      charge_nack_q   <= 1'b0;
      coin_reject_q   <= 1'b0;
      idle_q          <= 1'b1;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      refund_amount_q <= refund_amount_d;
      refund_valid_q  <= refund_valid_d;
      charge_ack_q    <= charge_ack_d;
      charge_nack_q   <= charge_nack_d;
      coin_reject_q   <= coin_reject_d;
      idle_q          <= idle_d;
    end
  end

  assign credit        = credit_q;
  assign charge_ack    = charge_ack_q;
  assign charge_nack   = charge_nack_q;
  assign coin_reject   = coin_reject_q;
  assign refund_valid  = refund_valid_q;
  assign refund_amount = refund_amount_q;
  assign idle          = idle_q;

endmodule

// File: tb/tb_coin_credit_unit.sv
// Directed bench for coin_credit_unit; the timeout steps run only when
// COIN_TIMEOUT_EN is defined (DUT built with TIMEOUT_S=3).
module tb_coin_credit_unit;

  logic       clk = 1'b0;
  logic       reset, tick_1s, coin_valid, charge_valid;
  logic       refund_req, session_end, refund_ack;
  logic [1:0] coin_code;
  logic [6:0] charge_amount;
  logic [6:0] credit, refund_amount;
  logic       charge_ack, charge_nack, coin_reject, refund_valid, idle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  coin_credit_unit #(.CREDIT_W(7), .MAX_CREDIT(75), .TIMEOUT_S(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .tick_1s       (tick_1s),
    .coin_valid    (coin_valid),
    .coin_code     (coin_code),
    .charge_valid  (charge_valid),
    .charge_amount (charge_amount),
    .refund_req    (refund_req),
    .session_end   (session_end),
    .refund_ack    (refund_ack),
    .credit        (credit),
    .charge_ack    (charge_ack),
    .charge_nack   (charge_nack),
    .coin_reject   (coin_reject),
    .refund_valid  (refund_valid),
    .refund_amount (refund_amount),
    .idle          (idle)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply current inputs for one edge, sample 1 time unit later, clear pulses
  task automatic step();
    @(posedge clk);
    #1;
    tick_1s = 0; coin_valid = 0; charge_valid = 0;
    refund_req = 0; session_end = 0; refund_ack = 0; reset = 0;
  endtask

  task automatic coin(input logic [1:0] c);
    coin_valid = 1; coin_code = c; step();
  endtask

  task automatic charge(input int amt);
    charge_valid = 1; charge_amount = 7'(amt); step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_credit"}, credit, 0);
    chk({tag, "_pulses"}, {charge_ack, charge_nack, coin_reject}, 0);
    chk({tag, "_rv"}, refund_valid, 0);
    chk({tag, "_ramt"}, refund_amount, 0);
    chk({tag, "_idle"}, idle, 1);
  endtask

  initial begin
    reset = 1; tick_1s = 0; coin_valid = 0; coin_code = 0; charge_valid = 0;
    charge_amount = 0; refund_req = 0; session_end = 0; refund_ack = 0;
    step();
    chk_reset_vals("rst");

    coin(2'd3); chk("c50", credit, 50); chk("c50_idle", idle, 0);
    coin(2'd2); chk("c20", credit, 70);
    coin(2'd0); chk("c5", credit, 75);
    coin(2'd1); chk("c10_rej", coin_reject, 1); chk("c10_cred", credit, 75);

    charge(30); chk("chg30_ack", charge_ack, 1); chk("chg30_cred", credit, 45);
    charge(45); chk("chg45_ack", charge_ack, 1); chk("chg45_cred", credit, 0);
    chk("chg45_idle", idle, 1);

    coin(2'd2); coin(2'd1); chk("build30", credit, 30);
    charge(45); chk("nack", charge_nack, 1); chk("nack_ack", charge_ack, 0);
    chk("nack_cred", credit, 30);

    coin(2'd2); coin(2'd1); coin(2'd1); chk("build70", credit, 70);
    charge_valid = 1; charge_amount = 60; coin_valid = 1; coin_code = 2'd3; step();
    chk("sim_ack", charge_ack, 1); chk("sim_rej", coin_reject, 0);
    chk("sim_cred", credit, 60);

    charge(35); chk("build25", credit, 25);
    session_end = 1; step();
    chk("ref_rv", refund_valid, 1); chk("ref_amt", refund_amount, 25);
    chk("ref_idle", idle, 0);
    coin(2'd1); chk("ref_coin_rej", coin_reject, 1); chk("ref_cred", credit, 25);
    charge(5); chk("ref_nack", charge_nack, 1); chk("ref_cred2", credit, 25);
    chk("ref_amt_hold", refund_amount, 25);
    refund_ack = 1; step();
    chk_reset_vals("ack");

    coin(2'd2); refund_req = 1; step();
    chk("r20_rv", refund_valid, 1); chk("r20_amt", refund_amount, 20);
    reset = 1; step();
    chk_reset_vals("midrst");
    refund_req = 1; step();
    chk("idle_req_rv", refund_valid, 0); chk("idle_req_idle", idle, 1);
    refund_ack = 1; step();
    chk("stray_ack_rv", refund_valid, 0);
    charge(0); chk("zero_ack", charge_ack, 1); chk("zero_cred", credit, 0);

`ifdef COIN_TIMEOUT_EN
    coin(2'd1); chk("to_cred", credit, 10);
    tick_1s = 1; step(); tick_1s = 1; step();
    coin(2'd0); chk("to_cred15", credit, 15);
    tick_1s = 1; step(); tick_1s = 1; step();
    chk("to_two", refund_valid, 0);
    tick_1s = 1; step();
    chk("to_three", refund_valid, 0);
    step();
    chk("to_rv", refund_valid, 1); chk("to_amt", refund_amount, 15);
    refund_ack = 1; step();
    chk("to_done", idle, 1);
`else
    coin(2'd1);
    for (int i = 0; i < 70; i++) begin
      tick_1s = 1; step();
    end
    chk("hold_rv", refund_valid, 0); chk("hold_cred", credit, 10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coin_credit_unit.md
# coin_credit_unit

Customer-credit accumulator directly upstream of the vending-machine top level. Accepts validated coin/note events, maintains the customer's running credit in units of 100, and answers single-cycle purchase charge requests from the user path with ack/nack. Returns leftover credit through a refund handshake at session end. Its `credit` output is the customer-cash value the top level displays and compares against line prices.

## Interface
- `CREDIT_W`, 7: credit width, in units of 100.
- `MAX_CREDIT`, 75: credit ceiling (7500).
- `TIMEOUT_S`, 60: inactivity timeout in seconds; used only with `COIN_TIMEOUT_EN`.

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `tick_1s` in 1: one-cycle pulse per second, from the frequency divider.
- `coin_valid` in 1: one-cycle pulse; a coin has been accepted mechanically.
- `coin_code` in 2: coin denomination code. 0=5, 1=10, 2=20, 3=50 (units of 100).
- `charge_valid` in 1: one-cycle purchase request from the user path.
- `charge_amount` in CREDIT_W: price to deduct.
- `refund_req` in 1: level or pulse; the customer requests return of credit.
- `session_end` in 1: one-cycle pulse from buy-end; treated as `refund_req`.
- `refund_ack` in 1: payout mechanism has taken `refund_amount`.
- `credit` out CREDIT_W: current credit, registered.
- `charge_ack` out 1: one-cycle pulse; the charge was applied.
- `charge_nack` out 1: one-cycle pulse; the charge was refused.
- `coin_reject` out 1: one-cycle pulse; the coin was returned and not credited.
- `refund_valid` out 1: the refund offer is pending.
- `refund_amount` out CREDIT_W: amount being refunded; stable while `refund_valid` is high.
- `idle` out 1: the block is in the IDLE state.

## Operation
- Reset values: `credit`=0, all pulses=0, `refund_valid`=0, `refund_amount`=0, `idle`=1, state=IDLE, timer=0.

- States:
  - IDLE: credit is 0.
  - CREDIT: credit is greater than 0.
  - REFUND: a refund offer is pending.

- Coin handling, in IDLE or CREDIT:
  - Compute `v` = value(`coin_code`).
  - If `credit` − (applied charge) + `v` ≤ `MAX_CREDIT`, add `v` to credit.
  - Otherwise pulse `coin_reject` and leave credit unchanged.
  - All arithmetic is done one bit wider than `CREDIT_W` to detect overflow.

- Charge handling:
  - Charge is evaluated against the pre-edge `credit`.
  - If `charge_amount` ≤ `credit` and the state is not REFUND: deduct the amount and pulse `charge_ack`.
  - Otherwise pulse `charge_nack`.
  - A charge of 0 is acked.

- Simultaneous coin and charge in the same cycle:
  - The charge is decided first, against the old credit.
  - The coin is then tested against (old − charge, if acked) + `v`.
  - Both effects land on the same edge.

- Refund entry:
  - `refund_req` or `session_end` in CREDIT enters REFUND.
  - On entry, `refund_amount` latches `credit` and `refund_valid` rises.
  - In IDLE, a refund request is ignored; no zero refund is ever offered.

- While in REFUND:
  - Every coin pulses `coin_reject`.
  - Every charge pulses `charge_nack`.
  - `credit` holds its value until acknowledged.

- Refund completion:
  - `refund_ack` while `refund_valid` is high clears `credit`, drops `refund_valid`, zeroes `refund_amount`, and moves to IDLE.
  - `refund_ack` without `refund_valid` is ignored.

- Transitions between IDLE and CREDIT follow `credit` after every update.

## Timing
- Every input is sampled on the rising edge of `clk`. Every output is registered.
- Coin or charge to updated `credit`: 1 cycle.
- `charge_ack`/`charge_nack` appear in the same cycle that `credit` updates.
- Request to `refund_valid`: 1 cycle.
- `refund_ack` to `refund_valid`=0 and `credit`=0: 1 cycle.
- Back-to-back coins and charges on consecutive cycles are all processed, with no dead cycles.
- `reset` asserted in any state, including mid-refund, returns to the reset values on the next edge. A pending refund is discarded.

## Configuration
- `COIN_TIMEOUT_EN` defined:
  - An inactivity counter increments on `tick_1s` while in CREDIT.
  - It clears on any coin, charge, or state change.
  - When it reaches `TIMEOUT_S`, it forces refund entry exactly as `refund_req` does.
- `COIN_TIMEOUT_EN` undefined:
  - No counter exists and `tick_1s` is unused.
  - Credit is held indefinitely.

## Structure
- Shared package `vm_pkg` holds:
  - the coin-code enum and its value table (5/10/20/50);
  - the `MAX_CREDIT` default;
  - the `credit_state_t` enum (IDLE/CREDIT/REFUND).
- One sub-module, `inactivity_timer`:
  - ports: tick, clear, enable, expired; parameter `TIMEOUT_S`;
  - instantiated only under `COIN_TIMEOUT_EN`.

## Test plan
- Coins 50, 20, 5 on consecutive cycles → `credit` = 50, 70, 75; then a coin of 10 → `coin_reject`, credit stays 75.
- Credit 45, charge 45 → `charge_ack`, credit 0, `idle`=1. Credit 30, charge 45 → `charge_nack`, credit stays 30.
- Credit 70, same-cycle charge 60 and coin 50 → `charge_ack`, no reject, credit 60.
- Credit 25, `session_end` → `refund_valid`=1 and `refund_amount`=25 next cycle. While pending, a coin is rejected and a charge is nacked. `refund_ack` → credit 0, IDLE.
- Credit 20, in REFUND, `reset` asserted → next cycle all outputs are at reset values. `refund_req` in IDLE → `refund_valid` stays 0.
- With `COIN_TIMEOUT_EN`, `TIMEOUT_S`=3: credit 10, three `tick_1s` pulses with no activity → refund entry with `refund_amount`=10. A coin after two ticks restarts the count.
